// File: rtl/tick_burst_gen_if.sv
// Handshake bundle between a burst requester and tick_burst_gen:
// start/count/gap/abort in, tick/busy/done back.
interface tick_burst_gen_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic         start;
  logic [N-1:0] count;
  logic [W-1:0] gap;
  logic         abort;
  logic         tick;
  logic         busy;
  logic         done;

  modport master (
    output start, count, gap, abort,
    input  tick, busy, done
  );

  modport slave (
    input  start, count, gap, abort,
    output tick, busy, done
  );
endinterface

// File: rtl/tick_burst_gen.sv
// Burst tick generator: after an accepted start it emits `count` single-cycle
// ticks spaced by `gap` idle cycles, then pulses done; abort cancels silently.
module tick_burst_gen #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  tick_burst_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TICK = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] remaining_q, remaining_d;
  logic [W-1:0] gap_cfg_q, gap_cfg_d;
  logic [W-1:0] gap_cnt_q, gap_cnt_d;
  logic         tick_q, busy_q, done_q;
  logic [N-1:0] rem_dec_s;

  // Saturating decrement keeps remaining from ever wrapping below zero.
  assign rem_dec_s = (remaining_q == N'(0)) ? N'(0) : remaining_q - N'(1);

  // Next-state and counter update rules.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_cfg_d   = gap_cfg_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          remaining_d = bus.count;
          gap_cfg_d   = bus.gap;
          gap_cnt_d   = W'(0);
          if (bus.count == N'(0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_TICK;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TICK: begin
        if (bus.abort) begin
          state_d     = S_IDLE;
          remaining_d = N'(0);
          gap_cnt_d   = W'(0);
        end else begin
          remaining_d = rem_dec_s;
          if (rem_dec_s == N'(0)) begin
            state_d = S_DONE;
          end else if (gap_cfg_q == W'(0)) begin
            state_d = S_TICK;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = gap_cfg_q - W'(1);
          end
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d     = S_IDLE;
          remaining_d = N'(0);
          gap_cnt_d   = W'(0);
        end else if (gap_cnt_q == W'(0)) begin
          state_d = S_TICK;
        end else begin
          gap_cnt_d = gap_cnt_q - W'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        remaining_d = N'(0);
        gap_cnt_d   = W'(0);
      end
    endcase
  end

  // State, counters and outputs; outputs are registered from the next state
  // so they always equal a decode of the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= N'(0);
      gap_cfg_q   <= W'(0);
      gap_cnt_q   <= W'(0);
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_cfg_q   <= gap_cfg_d;
      gap_cnt_q   <= gap_cnt_d;
      tick_q      <= (state_d == S_TICK);
      busy_q      <= (state_d == S_TICK) || (state_d == S_GAP);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.tick = tick_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_tick_burst_gen.sv
// Directed bench for tick_burst_gen: a timing-formula model checked every
// cycle, plus literal per-cycle expectations for each scenario.
module tb_tick_burst_gen;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int NONE = 32'h7fffffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tick_burst_gen_if #(.N(N), .W(W)) bus ();

  tick_burst_gen #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Cycle index: value of cyc after the edge that opens the cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: one accepted burst described by start cycle, count, gap, abort cycle.
  bit hb    = 1'b0;
  int bk    = 0;
  int bc    = 0;
  int bg    = 0;
  int ab_at = NONE;

  function automatic int m_last();
    return (bc == 0) ? 0 : 1 + (bc - 1) * (bg + 1);
  endfunction

  function automatic bit m_busy(input int n);
    return hb && (bc != 0) && (n >= bk + 1) && (n <= bk + m_last()) && (n <= ab_at);
  endfunction

  function automatic bit m_tick(input int n);
    return m_busy(n) && (((n - bk - 1) % (bg + 1)) == 0);
  endfunction

  function automatic bit m_done(input int n);
    return hb && (ab_at == NONE) && (n == bk + m_last() + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb    <= 1'b0;
      ab_at <= NONE;
    end else if (!m_busy(cyc)) begin
      if (bus.start) begin
        hb    <= 1'b1;
        bk    <= cyc;
        bc    <= int'(bus.count);
        bg    <= int'(bus.gap);
        ab_at <= NONE;
      end
    end else if (bus.abort) begin
      ab_at <= cyc;
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  int c_chk      = 0;
  int c_fail     = 0;
  int tick_total = 0;
  int done_total = 0;
  always @(negedge clk) begin : cmp
    int f;
    f = 0;
    if (bus.tick !== m_tick(cyc)) begin
      f = f + 1;
      $display("FAIL model_tick cyc=%0d got=%b want=%b", cyc, bus.tick, m_tick(cyc));
    end
    if (bus.busy !== m_busy(cyc)) begin
      f = f + 1;
      $display("FAIL model_busy cyc=%0d got=%b want=%b", cyc, bus.busy, m_busy(cyc));
    end
    if (bus.done !== m_done(cyc)) begin
      f = f + 1;
      $display("FAIL model_done cyc=%0d got=%b want=%b", cyc, bus.done, m_done(cyc));
    end
    c_chk      <= c_chk + 3;
    c_fail     <= c_fail + f;
    tick_total <= tick_total + ((bus.tick === 1'b1) ? 1 : 0);
    done_total <= done_total + ((bus.done === 1'b1) ? 1 : 0);
  end

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;
  int t0     = 0;
  int d0     = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic t, input logic b, input logic d);
    n_chk++;
    if ({bus.tick, bus.busy, bus.done} !== {t, b, d}) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got tick/busy/done=%b%b%b want=%b%b%b",
               name, cyc, bus.tick, bus.busy, bus.done, t, b, d);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Drives start for one cycle (k = start cycle) and scrambles count/gap after.
  task automatic start_burst(input int c, input int g);
    bus.start = 1'b1;
    bus.count = N'(c);
    bus.gap   = W'(g);
    k = cyc;
    step();
    bus.start = 1'b0;
    bus.count = N'(c ^ 5);
    bus.gap   = W'(g ^ 3);
  endtask

  logic [9:0] t2t;
  logic [9:0] t2b;
  logic [9:0] t2d;

  initial begin
    bus.start = 1'b0;
    bus.count = N'(0);
    bus.gap   = W'(0);
    bus.abort = 1'b0;
    #1;
    lit("reset_state", 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // count=3 gap=0
    t0 = tick_total;
    start_burst(3, 0);
    for (int i = 1; i <= 3; i++) begin
      lit("t1_tick", 1'b1, 1'b1, 1'b0);
      step();
    end
    lit("t1_done", 1'b0, 1'b0, 1'b1);
    step();
    lit("t1_idle", 1'b0, 1'b0, 1'b0);
    chk_int("t1_tick_count", tick_total - t0, 3);

    // count=3 gap=2: ticks at +1,+4,+7, done at +8
    t2t = 10'h092;
    t2b = 10'h0FE;
    t2d = 10'h100;
    start_burst(3, 2);
    for (int rel = 1; rel <= 9; rel++) begin
      lit("t2_pattern", t2t[rel], t2b[rel], t2d[rel]);
      step();
    end

    // count=0 gap=5
    start_burst(0, 5);
    lit("t3_done", 1'b0, 1'b0, 1'b1);
    step();
    lit("t3_after", 1'b0, 1'b0, 1'b0);
    step();

    // count=4 gap=1 with ignored restart at k+3, back-to-back at k+8
    t0 = tick_total;
    start_burst(4, 1);
    lit("t4_k1", 1'b1, 1'b1, 1'b0);
    step();
    lit("t4_k2", 1'b0, 1'b1, 1'b0);
    step();
    bus.start = 1'b1;
    bus.count = N'(9);
    bus.gap   = W'(0);
    lit("t4_k3", 1'b1, 1'b1, 1'b0);
    step();
    bus.start = 1'b0;
    lit("t4_k4", 1'b0, 1'b1, 1'b0);
    step();
    lit("t4_k5", 1'b1, 1'b1, 1'b0);
    step();
    lit("t4_k6", 1'b0, 1'b1, 1'b0);
    step();
    lit("t4_k7", 1'b1, 1'b1, 1'b0);
    step();
    lit("t4_k8_done", 1'b0, 1'b0, 1'b1);
    start_burst(2, 0);
    chk_int("t4_tick_count", tick_total - t0, 4);
    lit("t4_k9", 1'b1, 1'b1, 1'b0);
    step();
    lit("t4_k10", 1'b1, 1'b1, 1'b0);
    step();
    lit("t4_k11_done", 1'b0, 1'b0, 1'b1);
    step();

    // count=10 gap=0, abort in k+4
    t0 = tick_total;
    d0 = done_total;
    start_burst(10, 0);
    for (int i = 1; i <= 3; i++) begin
      lit("t5_tick", 1'b1, 1'b1, 1'b0);
      step();
    end
    bus.abort = 1'b1;
    lit("t5_k4", 1'b1, 1'b1, 1'b0);
    step();
    bus.abort = 1'b0;
    lit("t5_k5_stopped", 1'b0, 1'b0, 1'b0);
    repeat (12) step();
    chk_int("t5_tick_count", tick_total - t0, 4);
    chk_int("t5_no_done", done_total - d0, 0);

    // count=15 gap=3, async reset mid-gap after 5th tick
    t0 = tick_total;
    start_burst(15, 3);
    while (cyc < k + 18) step();
    lit("t6_in_gap", 1'b0, 1'b1, 1'b0);
    chk_int("t6_ticks_before_reset", tick_total - t0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    lit("t6_async_reset", 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    t0 = tick_total;
    d0 = done_total;
    repeat (20) step();
    chk_int("t6_no_ticks_after_reset", tick_total - t0, 0);
    chk_int("t6_no_done_after_reset", done_total - d0, 0);
    t0 = tick_total;
    start_burst(15, 0);
    for (int i = 1; i <= 15; i++) begin
      lit("t6_tick", 1'b1, 1'b1, 1'b0);
      step();
    end
    lit("t6_done", 1'b0, 1'b0, 1'b1);
    step();
    chk_int("t6_tick_count", tick_total - t0, 15);
    step();

    n_chk  = n_chk + c_chk;
    n_fail = n_fail + c_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tick_burst_gen.md
# tick_burst_gen

Producer counterpart of `tick_counter`: on a start request it emits a programmed number of single-cycle `tick` pulses, spaced by a programmable gap, then signals completion. It drives the `tick` input of `tick_counter` instances and of any other tick consumer, in both functional paths and self-checking benches. The design uses a start/busy/done handshake with an optional abort.

## Interface
- `N`, 4: width of the burst-length input; bursts of 0 to 2^N−1 ticks
- `W`, 8: width of the gap input; 0 to 2^W−1 idle cycles between ticks
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately
- `start` in 1: burst request; sampled only when the block is idle
- `count` in N: number of ticks; sampled with `start`
- `gap` in W: low cycles between consecutive ticks; sampled with `start`
- `abort` in 1: synchronous cancel of the current burst
- `tick` out 1: registered pulse, one cycle high per emitted tick
- `busy` out 1: burst in progress; `start` is ignored while high
- `done` out 1: one-cycle pulse on normal burst completion

## Operation
- States:
  - IDLE
  - TICK: `tick` high this cycle
  - GAP: waiting out the gap
  - DONE: `done` high this cycle
- Latched registers: `remaining` (N bits) and `gap_cfg` (W bits), plus a W-bit `gap_cnt`.
- IDLE, or DONE, with `start`=1:
  - Latch `count` and `gap`.
  - If `count`=0, go to DONE.
  - Otherwise go to TICK, with `remaining`=`count`.
- TICK:
  - Decrement `remaining`.
  - If the new `remaining` is 0, go to DONE.
  - Otherwise, if `gap_cfg`=0, go to TICK.
  - Otherwise go to GAP with `gap_cnt`=`gap_cfg`−1.
- GAP:
  - If `gap_cnt`=0, go to TICK.
  - Otherwise decrement `gap_cnt`.
- DONE without `start`: go to IDLE.
- Outputs are decoded from the registered state only:
  - `tick` = (state==TICK)
  - `busy` = (state==TICK or GAP)
  - `done` = (state==DONE)
- `abort`=1 in TICK or GAP:
  - Next state is IDLE and `done` is not pulsed.
  - `abort` has priority over all other transitions.
  - `abort` is ignored in IDLE and DONE.
- `start` while `busy`=1: ignored; the latched `count` and `gap` are unchanged.
- `count` and `gap` may change freely after the `start` cycle.
- `remaining` never underflows; arithmetic is unsigned and no value wraps.

## Timing
- Reset (`reset`=0): asynchronously forces state IDLE, with `tick`=`busy`=`done`=0 and all counters 0. Reset mid-burst drops the burst with no `done`. The first `start` is accepted on the first edge after `reset` returns to 1.
- Timing is counted from the `start` edge at cycle k:
  - Tick i (0-based) is high in cycle k+1+i·(gap+1).
  - Tick period is gap+1 cycles; `gap`=0 holds `tick` high for `count` consecutive cycles.
  - `done` is high in the cycle after the last tick: k+1+(count−1)·(gap+1)+1.
  - For `count`=0, `done` is high in cycle k+1 with no ticks and `busy` never high.
- `busy` is high from cycle k+1 through the last tick cycle inclusive, including gap cycles, and low in the `done` cycle.
- Back-to-back bursts:
  - `start` asserted in the `done` cycle is accepted.
  - The next first tick follows one cycle later, so there are no dead cycles between bursts beyond the `done` cycle.
- `abort` sampled at edge m: `tick` and `busy` are 0 from cycle m+1.
- Total ticks emitted always equals the sampled `count` unless the burst is aborted or reset.

## Test plan
- `count`=3, `gap`=0:
  - `tick` is high in cycles k+1..k+3 and `done` in k+4.
  - `busy` is high in k+1..k+3.
  - An attached `tick_counter` #(N=4) reads 3.
- `count`=3, `gap`=2:
  - Ticks occur at k+1, k+4 and k+7; `done` at k+8.
  - `tick` is low in all other cycles.
- `count`=0, `gap`=5: `done` is high at k+1, with no tick and `busy` never high.
- `count`=4, `gap`=1, with `start` pulsed again with `count`=9 in cycle k+3:
  - The second request is ignored.
  - Exactly 4 ticks are emitted and `done` is high at k+8.
  - A `start` in k+8 with `count`=2, `gap`=0 gives ticks at k+9 and k+10.
- `count`=10, `gap`=0, `abort` asserted in cycle k+4:
  - 4 ticks are emitted (k+1..k+4).
  - `busy` and `tick` are 0 from k+5 and `done` never pulses.
- `count`=15, `gap`=3, `reset` driven 0 mid-gap after the 5th tick:
  - `tick`, `busy` and `done` drop to 0 immediately (asynchronous reset), without waiting for a clock edge.
  - No further ticks follow after `reset` returns to 1.
  - A new `start` with `count`=15, `gap`=0 delivers exactly 15 ticks and `done` at k+16.
